// File: rtl/gbe_tx_arbiter.sv
// gbe_tx_arbiter: round-robin, frame-granular arbiter sharing the gbe_udp
// application TX port between NUM_SRC sources. Forwards the granted source's
// byte stream with one register stage, truncates oversize frames and drains
// their tails, and inserts a fixed idle gap between frames.
module gbe_tx_arbiter #(
    parameter int unsigned NUM_SRC         = 4,
    parameter int unsigned MAX_FRAME_BYTES = 1472,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic                    app_clk,
    input  logic                    app_rst,
    input  logic                    arb_enable,
    input  logic [NUM_SRC-1:0]      src_req,
    input  logic [8*NUM_SRC-1:0]    src_data,
    input  logic [NUM_SRC-1:0]      src_dvld,
    input  logic [NUM_SRC-1:0]      src_eof,
    input  logic [32*NUM_SRC-1:0]   src_destip,
    input  logic [16*NUM_SRC-1:0]   src_destport,
    output logic [NUM_SRC-1:0]      src_gnt,
    output logic [NUM_SRC-1:0]      src_afull,
    output logic [7:0]              app_tx_data,
    output logic                    app_tx_dvld,
    output logic                    app_tx_eof,
    output logic [31:0]             app_tx_destip,
    output logic [15:0]             app_tx_destport,
    input  logic                    app_tx_afull,
    output logic [31:0]             frames_sent,
    output logic [15:0]             trunc_count,
    output logic                    busy
);

    localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned CNT_W = 12;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_SRC-1:0]   gnt_q, gnt_d;
    logic [7:0]           data_q, data_d;
    logic                 dvld_q, dvld_d;
    logic                 eof_q, eof_d;
    logic [31:0]          destip_q, destip_d;
    logic [15:0]          destport_q, destport_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [31:0]          frames_q, frames_d;
    logic [15:0]          trunc_q, trunc_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [SEL_W-1:0]     win_idx;
    logic [7:0]           cur_data;
    logic                 cur_dvld;
    logic                 cur_eof;
    logic [CNT_W-1:0]     cnt_nxt;

    assign cur_data = src_data[{sel_q, 3'b000} +: 8];
    assign cur_dvld = src_dvld[sel_q];
    assign cur_eof  = src_eof[sel_q];
    assign cnt_nxt  = cnt_q + CNT_W'(1);

    // Round-robin search: first requester strictly after the pointer, wrapping.
    always_comb begin : rr_search
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!win_found && src_req[SEL_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = SEL_W'(cand);
            end
        end
    end

    // Next-state and registered-output logic for the grant/forward/drain/gap FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        data_d     = data_q;
        dvld_d     = 1'b0;
        eof_d      = 1'b0;
        destip_d   = destip_q;
        destport_d = destport_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        frames_d   = frames_q;
        trunc_d    = trunc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_enable && win_found) begin
                    state_d    = ST_ACTIVE;
                    ptr_d      = win_idx;
                    sel_d      = win_idx;
                    gnt_d      = NUM_SRC'(1) << win_idx;
                    destip_d   = src_destip[{win_idx, 5'b00000} +: 32];
                    destport_d = src_destport[{win_idx, 4'b0000} +: 16];
                    cnt_d      = '0;
                end
            end
            ST_ACTIVE: begin
                if (cur_dvld) begin
                    data_d = cur_data;
                    dvld_d = 1'b1;
                    cnt_d  = cnt_nxt;
                    if (cur_eof) begin
                        eof_d    = 1'b1;
                        frames_d = frames_q + 32'd1;
                        gnt_d    = '0;
                        gap_d    = '0;
                        state_d  = ST_GAP;
                    end else if (cnt_nxt == CNT_W'(MAX_FRAME_BYTES)) begin
                        // Oversize frame: close it here, discard the tail in DRAIN.
                        eof_d    = 1'b1;
                        frames_d = frames_q + 32'd1;
                        if (trunc_q != 16'hFFFF) begin
                            trunc_d = trunc_q + 16'd1;
                        end
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cur_dvld && cur_eof) begin
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; async reset clears everything, pointer primed so source 0 wins first.
    always_ff @(posedge app_clk or posedge app_rst) begin
        if (app_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= SEL_W'(NUM_SRC - 1);
            sel_q      <= '0;
            gnt_q      <= '0;
            data_q     <= '0;
            dvld_q     <= 1'b0;
            eof_q      <= 1'b0;
            destip_q   <= '0;
            destport_q <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            frames_q   <= '0;
            trunc_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            data_q     <= data_d;
            dvld_q     <= dvld_d;
            eof_q      <= eof_d;
            destip_q   <= destip_d;
            destport_q <= destport_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            frames_q   <= frames_d;
            trunc_q    <= trunc_d;
            busy_q     <= busy_d;
        end
    end

    // Back-pressure: ungranted sources always held off; a draining source is never held off.
    always_comb begin
        src_afull = ~gnt_q | {NUM_SRC{app_tx_afull && (state_q != ST_DRAIN)}};
    end

    assign src_gnt         = gnt_q;
    assign app_tx_data     = data_q;
    assign app_tx_dvld     = dvld_q;
    assign app_tx_eof      = eof_q;
    assign app_tx_destip   = destip_q;
    assign app_tx_destport = destport_q;
    assign frames_sent     = frames_q;
    assign trunc_count     = trunc_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// tb_gbe_tx_arbiter: directed bench for gbe_tx_arbiter with behavioural
// frame sources and an output monitor.
module tb_gbe_tx_arbiter;

    localparam int NS  = 4;
    localparam int MAX = 64;

    logic              app_clk;
    logic              app_rst;
    logic              arb_enable;
    logic [NS-1:0]     src_req;
    logic [8*NS-1:0]   src_data;
    logic [NS-1:0]     src_dvld;
    logic [NS-1:0]     src_eof;
    logic [32*NS-1:0]  src_destip;
    logic [16*NS-1:0]  src_destport;
    logic [NS-1:0]     src_gnt;
    logic [NS-1:0]     src_afull;
    logic [7:0]        app_tx_data;
    logic              app_tx_dvld;
    logic              app_tx_eof;
    logic [31:0]       app_tx_destip;
    logic [15:0]       app_tx_destport;
    logic              app_tx_afull;
    logic [31:0]       frames_sent;
    logic [15:0]       trunc_count;
    logic              busy;

    gbe_tx_arbiter #(
        .NUM_SRC         (NS),
        .MAX_FRAME_BYTES (MAX),
        .GAP_CYCLES      (2)
    ) dut (
        .app_clk         (app_clk),
        .app_rst         (app_rst),
        .arb_enable      (arb_enable),
        .src_req         (src_req),
        .src_data        (src_data),
        .src_dvld        (src_dvld),
        .src_eof         (src_eof),
        .src_destip      (src_destip),
        .src_destport    (src_destport),
        .src_gnt         (src_gnt),
        .src_afull       (src_afull),
        .app_tx_data     (app_tx_data),
        .app_tx_dvld     (app_tx_dvld),
        .app_tx_eof      (app_tx_eof),
        .app_tx_destip   (app_tx_destip),
        .app_tx_destport (app_tx_destport),
        .app_tx_afull    (app_tx_afull),
        .frames_sent     (frames_sent),
        .trunc_count     (trunc_count),
        .busy            (busy)
    );

    initial app_clk = 1'b0;
    always #5 app_clk = ~app_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // source model state
    int rem[NS];
    int nfr[NS];
    int flen[NS];
    int seqn[NS];
    int first_in_cyc[NS];

    // monitor logs
    logic [7:0]    obs_data[$];
    bit            obs_eof[$];
    int            eof_cyc[$];
    int            gnt_src[$];
    int            gnt_cyc[$];
    int            first_out_cyc;
    logic [NS-1:0] prev_gnt;

    int exp_src[8];
    int exp_len[8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic src_reset();
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0;
            nfr[i] = 0;
            flen[i] = 0;
            seqn[i] = 0;
        end
        src_req  = '0;
        src_dvld = '0;
        src_eof  = '0;
        src_data = '0;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_eof.delete();
        eof_cyc.delete();
        gnt_src.delete();
        gnt_cyc.delete();
        first_out_cyc = -1;
        for (int i = 0; i < NS; i++) first_in_cyc[i] = -1;
    endtask

    task automatic start_src(input int i, input int len, input int n,
                             input logic [31:0] ip, input logic [15:0] port);
        flen[i] = len;
        nfr[i]  = n;
        src_req[i] = 1'b1;
        src_destip[32*i +: 32]   = ip;
        src_destport[16*i +: 16] = port;
    endtask

    task automatic wait_frames(input string tag, input logic [31:0] n);
        int k = 0;
        while (frames_sent != n && k < 2000) begin
            @(posedge app_clk); #2;
            k++;
        end
        chk({tag, "_frames"}, frames_sent, n);
    endtask

    task automatic wait_gnt(input string tag, input logic [NS-1:0] g);
        int k = 0;
        while (src_gnt != g && k < 200) begin
            @(posedge app_clk); #2;
            k++;
        end
        chk({tag, "_gnt"}, 32'(src_gnt), 32'(g));
    endtask

    task automatic wait_obs(input string tag, input int n);
        int k = 0;
        while (obs_data.size() < n && k < 500) begin
            @(posedge app_clk); #2;
            k++;
        end
        chk({tag, "_obs"}, 32'(obs_data.size() >= n), 32'd1);
    endtask

    task automatic wait_src_done(input string tag, input int i);
        int k = 0;
        while ((rem[i] + nfr[i]) != 0 && k < 2000) begin
            @(posedge app_clk); #2;
            k++;
        end
        chk({tag, "_srcdone"}, 32'(rem[i] + nfr[i]), 32'd0);
    endtask

    // Compare the logged output stream against expected frames (source, length).
    task automatic check_frames(input string tag, input int n);
        int bad   = 0;
        int pos   = 0;
        int total = 0;
        for (int f = 0; f < n; f++) begin
            total += exp_len[f];
            for (int b = 0; b < exp_len[f]; b++) begin
                if (pos < obs_data.size()) begin
                    if (obs_data[pos] !== 8'(exp_src[f] * 64 + b % 64) ||
                        obs_eof[pos] != (b == exp_len[f] - 1)) bad++;
                end
                pos++;
            end
            chk($sformatf("%s_order%0d", tag, f),
                32'((f < gnt_src.size()) ? gnt_src[f] : -1), 32'(exp_src[f]));
        end
        chk({tag, "_len"}, 32'(obs_data.size()), 32'(total));
        chk({tag, "_bytes"}, 32'(bad), 32'd0);
    endtask

    task automatic do_reset();
        app_rst = 1'b1;
        src_reset();
        repeat (2) @(posedge app_clk);
        #2;
        app_rst = 1'b0;
    endtask

    // Behavioural sources: send when granted and not held off.
    initial begin
        forever begin
            @(negedge app_clk);
            for (int i = 0; i < NS; i++) begin
                src_dvld[i] = 1'b0;
                src_eof[i]  = 1'b0;
                if (rem[i] == 0 && nfr[i] > 0) begin
                    rem[i]  = flen[i];
                    seqn[i] = 0;
                    nfr[i]--;
                end
                src_req[i] = (rem[i] > 0);
                if (rem[i] > 0 && src_gnt[i] && !src_afull[i] && !app_rst) begin
                    src_dvld[i] = 1'b1;
                    src_data[8*i +: 8] = 8'(i * 64 + seqn[i] % 64);
                    src_eof[i] = (rem[i] == 1);
                    if (first_in_cyc[i] < 0) first_in_cyc[i] = cyc;
                    seqn[i]++;
                    rem[i]--;
                end
            end
        end
    end

    // Output monitor: logs forwarded bytes and grant events.
    initial begin
        prev_gnt = '0;
        forever begin
            @(posedge app_clk);
            cyc++;
            #1;
            if (app_tx_dvld) begin
                obs_data.push_back(app_tx_data);
                obs_eof.push_back(app_tx_eof);
                if (app_tx_eof) eof_cyc.push_back(cyc);
                if (first_out_cyc < 0) first_out_cyc = cyc;
            end
            if (src_gnt != '0 && prev_gnt == '0) begin
                for (int i = 0; i < NS; i++) begin
                    if (src_gnt[i]) gnt_src.push_back(i);
                end
                gnt_cyc.push_back(cyc);
            end
            prev_gnt = src_gnt;
        end
    end

    initial begin
        int sz0;
        int k;
        int neof;
        app_rst      = 1'b1;
        arb_enable   = 1'b1;
        app_tx_afull = 1'b0;
        src_destip   = '0;
        src_destport = '0;
        src_reset();
        clear_obs();
        repeat (3) @(posedge app_clk);
        #2;

        // reset state
        chk("rst_gnt", 32'(src_gnt), 32'd0);
        chk("rst_afull", 32'(src_afull), 32'hF);
        chk("rst_dvld", 32'(app_tx_dvld), 32'd0);
        chk("rst_eof", 32'(app_tx_eof), 32'd0);
        chk("rst_destip", app_tx_destip, 32'd0);
        chk("rst_frames", frames_sent, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        app_rst = 1'b0;
        @(posedge app_clk); #2;

        // single 64-byte frame from source 0 (exactly at the length limit)
        clear_obs();
        start_src(0, 64, 1, 32'h0A000002, 16'h1234);
        @(posedge app_clk); #2;
        chk("t1_gnt", 32'(src_gnt), 32'h1);
        chk("t1_destip", app_tx_destip, 32'h0A000002);
        chk("t1_destport", 32'(app_tx_destport), 32'h1234);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_frames("t1", 32'd1);
        chk("t1_latency", 32'(first_out_cyc - first_in_cyc[0]), 32'd1);
        exp_src[0] = 0; exp_len[0] = 64;
        check_frames("t1", 1);
        chk("t1_trunc", 32'(trunc_count), 32'd0);

        // four sources contending, 8-byte frames
        do_reset();
        clear_obs();
        start_src(0, 8, 2, 32'h0A000010, 16'h0010);
        start_src(1, 8, 1, 32'h0A000011, 16'h0011);
        start_src(2, 8, 1, 32'h0A000012, 16'h0012);
        start_src(3, 8, 1, 32'h0A000013, 16'h0013);
        wait_frames("t2", 32'd5);
        exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 2; exp_src[3] = 3; exp_src[4] = 0;
        for (int f = 0; f < 5; f++) exp_len[f] = 8;
        check_frames("t2", 5);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("t2_gap%0d", f),
                32'((gnt_cyc.size() > f + 1 && eof_cyc.size() > f) ?
                    gnt_cyc[f+1] - eof_cyc[f] : -1), 32'd3);
        end

        // truncation: source 2 sends 100 bytes, limit 64
        repeat (4) @(posedge app_clk); #2;
        clear_obs();
        start_src(2, 100, 1, 32'hC0A80102, 16'h0BB8);
        k = 0;
        while (trunc_count != 16'd1 && k < 2000) begin
            @(posedge app_clk); #2;
            k++;
        end
        chk("t3_trunc", 32'(trunc_count), 32'd1);
        chk("t3_forced_eof", 32'(app_tx_eof), 32'd1);
        chk("t3_drain_gnt", 32'(src_gnt), 32'h4);
        chk("t3_drain_afull", 32'(src_afull), 32'hB);
        @(posedge app_clk); #2;
        chk("t3_drain_dvld", 32'(app_tx_dvld), 32'd0);
        chk("t3_hold_gnt", 32'(src_gnt), 32'h4);
        wait_src_done("t3", 2);
        repeat (2) @(posedge app_clk); #2;
        chk("t3_gnt_drop", 32'(src_gnt), 32'd0);
        chk("t3_frames", frames_sent, 32'd6);
        chk("t3_destip", app_tx_destip, 32'hC0A80102);
        exp_src[0] = 2; exp_len[0] = 64;
        check_frames("t3", 1);

        // back-pressure stall mid-frame on source 3
        repeat (4) @(posedge app_clk); #2;
        clear_obs();
        start_src(3, 30, 1, 32'h0A000033, 16'h3333);
        wait_obs("t4", 10);
        app_tx_afull = 1'b1;
        #1;
        chk("t4_afull_on", 32'(src_afull), 32'hF);
        sz0 = obs_data.size();
        repeat (10) @(posedge app_clk);
        #2;
        chk("t4_stall_bytes", 32'(obs_data.size() - sz0), 32'd0);
        app_tx_afull = 1'b0;
        #1;
        chk("t4_afull_off", 32'(src_afull), 32'h7);
        wait_frames("t4", 32'd7);
        exp_src[0] = 3; exp_len[0] = 30;
        check_frames("t4", 1);

        // arb_enable low: in-flight frame completes, no new grant until re-enabled
        repeat (4) @(posedge app_clk); #2;
        clear_obs();
        start_src(0, 20, 1, 32'h0A000040, 16'h4040);
        wait_gnt("t5a", 4'h1);
        arb_enable = 1'b0;
        start_src(1, 8, 1, 32'h0A000041, 16'h4141);
        wait_frames("t5a", 32'd8);
        repeat (10) @(posedge app_clk); #2;
        chk("t5_no_gnt", 32'(src_gnt), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        arb_enable = 1'b1;
        @(posedge app_clk); #2;
        chk("t5_gnt_on_enable", 32'(src_gnt), 32'h2);
        chk("t5_destport", 32'(app_tx_destport), 32'h4141);
        wait_frames("t5b", 32'd9);
        exp_src[0] = 0; exp_len[0] = 20;
        exp_src[1] = 1; exp_len[1] = 8;
        check_frames("t5", 2);

        // asynchronous reset mid-frame
        repeat (4) @(posedge app_clk); #2;
        clear_obs();
        start_src(2, 40, 1, 32'h0A000050, 16'h5050);
        wait_obs("t6", 5);
        @(negedge app_clk); #2;
        app_rst = 1'b1;
        #1;
        chk("t6_gnt", 32'(src_gnt), 32'd0);
        chk("t6_dvld", 32'(app_tx_dvld), 32'd0);
        chk("t6_data", 32'(app_tx_data), 32'd0);
        chk("t6_destip", app_tx_destip, 32'd0);
        chk("t6_frames", frames_sent, 32'd0);
        chk("t6_trunc", 32'(trunc_count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        neof = 0;
        foreach (obs_eof[j]) if (obs_eof[j]) neof++;
        chk("t6_no_eof", 32'(neof), 32'd0);
        src_reset();
        repeat (2) @(posedge app_clk);
        #2;
        app_rst = 1'b0;
        start_src(1, 8, 1, 32'h0A000061, 16'h6161);
        start_src(3, 8, 1, 32'h0A000063, 16'h6363);
        @(posedge app_clk); #2;
        chk("t6_first_gnt", 32'(src_gnt), 32'h2);
        wait_frames("t6", 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gbe_tx_arbiter.md
Name: gbe_tx_arbiter

Overview:
Shares the single gbe_udp application TX interface (app_tx_*) between NUM_SRC independent frame sources in the app_clk domain. Grants whole frames in round-robin order, multiplexes and registers the granted source's byte stream, and propagates almost-full back-pressure to the granted source only. Enforces a maximum frame length by truncating oversize frames, and inserts a programmable idle gap between frames.

Parameters:
NUM_SRC, 4, number of requesters (2..8)
MAX_FRAME_BYTES, 1472, payload bytes per frame before forced EOF (1..4095)
GAP_CYCLES, 2, idle cycles between frames (1..15)

Ports:
app_clk  in  1  application clock
app_rst  in  1  asynchronous active-high reset
arb_enable  in  1  allow new grants; a frame in progress always completes
src_req  in  NUM_SRC  per-source frame request, held until the source's EOF byte
src_data  in  8*NUM_SRC  flattened payload bytes, source i at [8i+7:8i]
src_dvld  in  NUM_SRC  byte valid
src_eof  in  NUM_SRC  last byte of frame, qualified by dvld
src_destip  in  32*NUM_SRC  destination IP, sampled at grant
src_destport  in  16*NUM_SRC  destination port, sampled at grant
src_gnt  out  NUM_SRC  one-hot grant
src_afull  out  NUM_SRC  back-pressure; bit i = app_tx_afull | ~src_gnt[i]
app_tx_data  out  8  to gbe_udp
app_tx_dvld  out  1
app_tx_eof  out  1
app_tx_destip  out  32
app_tx_destport  out  16
app_tx_afull  in  1  from gbe_udp
frames_sent  out  32  frames completed, wraps
trunc_count  out  16  frames truncated, saturates at 0xFFFF
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = NUM_SRC-1, so the first grant searches from source 0.
- States: IDLE, ACTIVE, DRAIN, GAP.
- IDLE: if arb_enable and any src_req, select the first requesting source after the pointer (wrapping), then:
  - assert src_gnt next cycle;
  - latch that source's destip/destport into app_tx_destip/destport;
  - move the pointer to the winner;
  - go to ACTIVE.
- ACTIVE, forwarding: app_tx_data, dvld and eof are registered copies of the granted source's signals (1-cycle latency). dvld/eof from ungranted sources are ignored.
- ACTIVE, byte counter: 12 bits, cleared at grant, incremented per forwarded byte.
- ACTIVE, normal end: on a forwarded byte with eof, go to GAP and increment frames_sent.
- ACTIVE, truncation: if the byte making the count equal MAX_FRAME_BYTES arrives without eof:
  - force app_tx_eof on that byte;
  - increment frames_sent and trunc_count;
  - go to DRAIN.
  - If that byte carries eof itself, it is a normal end (no truncation).
- DRAIN: keep the grant, set src_afull of the granted source to 0, discard bytes (app_tx_dvld = 0) until the source's eof, then go to GAP.
- GAP: src_gnt = 0. Count GAP_CYCLES cycles, then go to IDLE. The earliest next grant appears GAP_CYCLES+1 cycles after the last forwarded byte.
- app_tx_destip/destport hold their value from grant until the next grant.
- src_gnt drops on the cycle after the EOF byte is accepted.
- Back-pressure:
  - Sources must not assert dvld while their src_afull is high.
  - app_tx_afull is passed through combinationally to the granted source's src_afull.
  - The arbiter does not buffer; gbe_udp's FIFO afull margin absorbs the 1-cycle register latency.
- A source deasserting src_req mid-frame has no effect; the frame ends only on eof (or truncation and drain).
- arb_enable low during ACTIVE/DRAIN: the frame completes normally; no new grant is issued until arb_enable is high again.
- Asynchronous reset mid-frame: outputs clear immediately and no EOF is emitted. The partial frame is flushed by the system asserting gbe_udp's app_tx_rst.

Test Plan:
- Single source 0, 64-byte frame, destip 0x0A000002, port 0x1234 -> gnt[0] one cycle after req; 64 bytes on app_tx with 1-cycle latency; eof on byte 64; destip/port correct; frames_sent = 1.
- All 4 sources requesting continuously, 8-byte frames, GAP_CYCLES = 2 -> grant order 0,1,2,3,0; exactly 3 idle cycles between last byte and next gnt; no byte from an ungranted source reaches app_tx.
- MAX_FRAME_BYTES = 16, source 2 sends 40 bytes -> app_tx carries 16 bytes with eof on byte 16; remaining 24 bytes dropped; trunc_count = 1; gnt[2] held until source eof.
- app_tx_afull high for 10 cycles mid-frame -> src_afull of the granted source high in the same cycle, others also high (ungranted); no bytes lost; frame byte count preserved.
- arb_enable low with requests pending -> no grant; a frame already in progress completes; grant issued on the first IDLE cycle after arb_enable rises.
- app_rst asserted mid-frame -> all outputs 0 asynchronously; after release, the next grant goes to source 0.
